// File: rtl/fifo_wr_ctrl.sv
// Write-side controller of the async FIFO (clk_wr domain): drives the tp_ram write port,
// owns the binary/Gray write pointer and derives full/almost_full/level/overflow.
module fifo_wr_ctrl #(
    parameter int DEPTH        = 16,
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 4,
    parameter int SYNC_STAGES  = 2,
    parameter int AFULL_THRESH = 14
) (
    input  logic                  clk_wr,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic [ADDR_WIDTH:0]   rd_ptr_gray,
    output logic                  en_wr,
    output logic [ADDR_WIDTH-1:0] addr_wr,
    output logic [DATA_WIDTH-1:0] data_wr,
    output logic [ADDR_WIDTH:0]   wr_ptr_gray,
    output logic                  full,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   wr_count,
    output logic                  overflow
);

    localparam int AW = ADDR_WIDTH;
    localparam int PW = ADDR_WIDTH + 1;
    localparam logic [AW:0] AFULL_LVL = PW'(AFULL_THRESH);

    if (DEPTH != (1 << ADDR_WIDTH)) begin : g_bad_depth
        $error("fifo_wr_ctrl: DEPTH must equal 2**ADDR_WIDTH");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("fifo_wr_ctrl: SYNC_STAGES must be at least 2");
    end
    if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_afull
        $error("fifo_wr_ctrl: AFULL_THRESH must lie in 1..DEPTH");
    end

    logic [AW:0] wr_bin_q, wr_bin_d;
    logic [AW:0] wr_gray_q, wr_gray_d;
    logic [AW:0] sync_q [SYNC_STAGES];
    logic [AW:0] rq_gray, rq_bin;
    logic [AW:0] level_d, count_q;
    logic        full_q, full_d;
    logic        afull_q, afull_d;
    logic        ovf_q, ovf_d;
    logic        push;

    // Qualifying with rst_n guarantees no RAM write while reset is held.
    assign push = wr_en & ~full_q & ~rst_n;

    assign rq_gray = sync_q[SYNC_STAGES-1];

    always_comb begin
        rq_bin = '0;
        for (int i = 0; i <= AW; i++) begin
            rq_bin[i] = ^(rq_gray >> i);
        end
    end

    always_comb begin
        wr_bin_d  = wr_bin_q + {{AW{1'b0}}, push};
        wr_gray_d = wr_bin_d ^ (wr_bin_d >> 1);
        level_d   = wr_bin_d - rq_bin;
        // Full when the write pointer is exactly one lap ahead of the synced read pointer.
        full_d    = (wr_gray_d == {~rq_gray[AW:AW-1], rq_gray[AW-2:0]});
        afull_d   = (level_d >= AFULL_LVL);
        ovf_d     = wr_en & full_q;
    end

    always_ff @(posedge clk_wr or posedge rst_n) begin
        if (rst_n) begin
            wr_bin_q  <= '0;
            wr_gray_q <= '0;
            count_q   <= '0;
            full_q    <= 1'b0;
            afull_q   <= 1'b0;
            ovf_q     <= 1'b0;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            wr_bin_q  <= wr_bin_d;
            wr_gray_q <= wr_gray_d;
            count_q   <= level_d;
            full_q    <= full_d;
            afull_q   <= afull_d;
            ovf_q     <= ovf_d;
            sync_q[0] <= rd_ptr_gray;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign en_wr       = push;
    assign addr_wr     = wr_bin_q[AW-1:0];
    assign data_wr     = din;
    assign wr_ptr_gray = wr_gray_q;
    assign full        = full_q;
    assign almost_full = afull_q;
    assign wr_count    = count_q;
    assign overflow    = ovf_q;

endmodule

// File: doc/fifo_wr_ctrl.md
Name: fifo_wr_ctrl

Overview:
Write-side controller of the asynchronous FIFO, in the clk_wr domain. Sits directly upstream of tp_ram and drives its write port (en_wr, addr_wr, data_wr). Keeps the binary/Gray write pointer and synchronises the read-domain Gray pointer. Generates full, almost_full, a pessimistic fill level, and an overflow pulse.

Parameters:
DEPTH, 16, FIFO depth in words; must equal 2**ADDR_WIDTH
DATA_WIDTH, 8, data word width
ADDR_WIDTH, 4, RAM address width; pointers are ADDR_WIDTH+1 bits
SYNC_STAGES, 2, flop stages on the incoming read pointer (>=2)
AFULL_THRESH, 14, fill level at or above which almost_full asserts (1..DEPTH)

Ports:
clk_wr  in  1  write-domain clock
rst_n  in  1  reset: asynchronous, active-high (asserted when 1)
wr_en  in  1  push request from producer
din  in  DATA_WIDTH  push data
rd_ptr_gray  in  ADDR_WIDTH+1  read pointer, Gray-coded, from read domain (asynchronous)
en_wr  out  1  tp_ram write enable
addr_wr  out  ADDR_WIDTH  tp_ram write address
data_wr  out  DATA_WIDTH  tp_ram write data
wr_ptr_gray  out  ADDR_WIDTH+1  registered Gray write pointer, to read domain
full  out  1  FIFO full; pushes ignored
almost_full  out  1  fill level >= AFULL_THRESH
wr_count  out  ADDR_WIDTH+1  fill level as seen from write domain (0..DEPTH)
overflow  out  1  one-cycle pulse: push attempted while full

Behaviour:
- Reset (rst_n=1, async): wr_bin=0, wr_ptr_gray=0, all sync flops=0, full=0, almost_full=0, wr_count=0, overflow=0. Outputs hold these values while rst_n=1. Release is synchronous to clk_wr.
- Accept: push = wr_en & ~full (combinational).
- RAM port is combinational from the current state: en_wr=push, addr_wr=wr_bin[ADDR_WIDTH-1:0], data_wr=din. tp_ram captures the word on the same clk_wr edge that advances the pointer. There is zero-cycle latency from the accepted push to the RAM write.
- Pointer: wr_bin_next = wr_bin + push, modulo 2**(ADDR_WIDTH+1). wr_ptr_gray <= wr_bin_next ^ (wr_bin_next>>1), registered. Exactly one bit changes per increment.
- Sync: rd_ptr_gray passes through SYNC_STAGES flops to give rq_gray. No logic sits between the stages. rq_bin is the Gray-to-binary conversion of rq_gray.
- full <= (gray(wr_bin_next) == {~rq_gray[AW:AW-1], rq_gray[AW-2:0]}), registered. full asserts on the edge that accepts the DEPTH-th outstanding word.
- wr_count <= wr_bin_next - rq_bin, modulo 2**(ADDR_WIDTH+1). The value is conservative: it over-reports by the pops not yet synchronised.
- almost_full <= (wr_bin_next - rq_bin) >= AFULL_THRESH.
- overflow <= wr_en & full, registered. It is a single-cycle pulse per offending cycle. The pointer, en_wr and RAM are unaffected.
- Full release latency: a read-pointer change at the input deasserts full after SYNC_STAGES+1 clk_wr edges, i.e. 3 with the defaults.
- Wrap-around: addr_wr goes from DEPTH-1 to 0. The pointer MSB toggles every DEPTH pushes. Gray code wraps from 10000 to 00000 for AW=4.
- Simultaneous push and incoming pop: both are folded into the same-edge computation. full stays 0 if the synchronised pop and the push leave the level below DEPTH.
- Reset mid-operation forces the empty state immediately. en_wr drops combinationally with full/state cleared, so no RAM write occurs while rst_n=1. The read side must be reset together.
- Elaboration: error if DEPTH != 2**ADDR_WIDTH, SYNC_STAGES < 2, or AFULL_THRESH is outside 1..DEPTH.

Test Plan:
- Reset: rst_n=1 then release, rd_ptr_gray=0 -> full=0, almost_full=0, wr_count=0, wr_ptr_gray=00000, en_wr=0 with wr_en=0.
- Fill: 16 pushes din=i*10, rd_ptr_gray=0 -> en_wr=1 with addr_wr=0..15, data_wr=0..150. almost_full=1 after the 14th push, full=1 after the 16th, wr_count=16, wr_ptr_gray=11000.
- Overflow: wr_en=1 for 2 cycles while full -> en_wr=0, overflow=1 for 2 cycles, wr_ptr_gray stays 11000, wr_count stays 16.
- Full release: from full, set rd_ptr_gray=00001 -> full=0 exactly 3 clk_wr edges later, wr_count=15. The next push writes addr_wr=0.
- Wrap: 32 pushes with rd_ptr_gray following 2 words behind -> full never set, addr_wr wraps 15->0 twice, wr_ptr_gray returns to 00000.
- Reset mid-fill: after 5 pushes, pulse rst_n=1 with wr_en=1 held -> en_wr=0 and wr_count=0 during reset. First push after release uses addr_wr=0.
